// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_if
//  Description : Bundle for the instruction-memory loader. Carries the load
//                command, the byte-stream handshake, the instruction-memory
//                write port and the core release / status lines.
//                  load_start  : one-cycle pulse starting a program load
//                  byte_valid  : byte_data holds a valid byte
//                  byte_data   : program stream byte (8 bits)
//                  byte_ready  : loader accepts a byte this cycle
//                  imem_we     : instruction-memory write strobe
//                  imem_addr   : write byte address (32 bits)
//                  imem_wdata  : write data (32 bits)
//                  core_rst_n  : active-low core reset, low while loading
//                  done        : program loaded, core released
//                  err         : header length invalid
//                master = stream source / system side, slave = loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if;
    logic        load_start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        done;
    logic        err;

    modport master (
        output load_start, byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata, core_rst_n, done, err
    );

    modport slave (
        input  load_start, byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata, core_rst_n, done, err
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Loads a program into instruction memory from a byte stream.
//                Stream format: 16-bit little-endian word count followed by
//                the words, each little-endian. Holds the core in reset while
//                loading and releases it once every word has been written.
//  Ports       : clk  - single clock, rising edge
//                rst  - asynchronous active-high reset
//                bus  - imem_loader_if.slave (stream handshake, imem write
//                       port, core_rst_n / done / err)
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int          IMEM_WORDS = 256,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  wire logic       clk,
    input  wire logic       rst,
    imem_loader_if.slave    bus
);

    localparam logic [16:0] C_MAX_WORDS = 17'(IMEM_WORDS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] widx_q, widx_d;
    logic [1:0]  bidx_q, bidx_d;
    logic [23:0] asm_q, asm_d;        // bytes 0..2 of the word being assembled
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        last_q, last_d;      // final byte of the program captured
    logic        done_q, err_q, core_rst_n_q;

    logic        w_byte_ready;
    logic        w_xfer;
    logic [15:0] w_len;
    logic        w_len_bad;

    // After the final byte the loader stops accepting even though the FSM
    // stays in DATA for the write cycle of the last word.
    assign w_byte_ready = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                          ((state_q == DATA) && !last_q);
    assign w_xfer       = bus.byte_valid && w_byte_ready;

    assign w_len     = {bus.byte_data, len_q[7:0]};
    assign w_len_bad = (w_len == 16'd0) || ({1'b0, w_len} > C_MAX_WORDS);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        widx_d  = widx_q;
        bidx_d  = bidx_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (bus.load_start) begin
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (w_xfer) begin
                    len_d[7:0] = bus.byte_data;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (w_xfer) begin
                    len_d[15:8] = bus.byte_data;
                    widx_d      = 16'd0;
                    bidx_d      = 2'd0;
                    last_d      = 1'b0;
                    state_d     = w_len_bad ? ERR : DATA;
                end
            end
            DATA: begin
                if (w_xfer) begin
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        // Word complete: move it into the write register so a
                        // byte accepted during the write cycle can start the
                        // next word in asm_q without disturbing it.
                        we_d    = 1'b1;
                        wdata_d = {bus.byte_data, asm_q};
                        addr_d  = BASE_ADDR + {14'd0, widx_q, 2'b00};
                        widx_d  = widx_q + 16'd1;
                        if (widx_q == (len_q - 16'd1)) begin
                            last_d = 1'b1;
                        end
                    end else begin
                        asm_d[{bidx_q, 3'b000} +: 8] = bus.byte_data;
                    end
                end
                if (we_q && last_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.load_start) begin
                    state_d = LEN_LO;
                end
            end
            ERR: begin
                if (bus.load_start) begin
                    state_d = LEN_LO;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= 16'd0;
            widx_q       <= 16'd0;
            bidx_q       <= 2'd0;
            asm_q        <= 24'd0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            widx_q       <= widx_d;
            bidx_q       <= bidx_d;
            asm_q        <= asm_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            last_q       <= last_d;
            // Status outputs are registered from the next state so they line
            // up exactly with the state they describe.
            done_q       <= (state_d == DONE);
            err_q        <= (state_d == ERR);
            core_rst_n_q <= (state_d == DONE);
        end
    end

    assign bus.byte_ready = w_byte_ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.core_rst_n = core_rst_n_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. Stimulus pushes the
//                expected memory writes into a queue; a monitor pops and
//                compares on every imem_we cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int          IMEM_WORDS = 256;
    localparam logic [31:0] BASE       = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_loader_if bus();

    imem_loader #(
        .IMEM_WORDS (IMEM_WORDS),
        .BASE_ADDR  (BASE)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] words[$];
    int          total = 0;
    int          bad   = 0;
    logic        prev_we = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            prev_we = 1'b0;
        end else begin
            if (bus.imem_we) begin
                check("we_one_cycle", {31'd0, prev_we}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("waddr", bus.imem_addr, mon_e.addr);
                    check("wdata", bus.imem_wdata, mon_e.data);
                end
            end
            prev_we = bus.imem_we;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bytes offered while the loader is not ready must be ignored.
    task automatic garbage();
        repeat (3) begin
            bus.byte_valid = 1'b1;
            bus.byte_data  = 8'($urandom);
            tick();
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        check("start_done_low",  {31'd0, bus.done},       32'd0);
        check("start_err_low",   {31'd0, bus.err},        32'd0);
        check("start_core_rst",  {31'd0, bus.core_rst_n}, 32'd0);
        check("start_ready",     {31'd0, bus.byte_ready}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        logic acc;
        int   n;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                bus.byte_valid = 1'b0;
                bus.byte_data  = 8'($urandom);
                tick();
            end
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            acc = bus.byte_ready;
            tick();
            n++;
        end
        if (!acc) check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    // Reference model: word i of the program lands at BASE + 4*i.
    task automatic run_load(input int n, input bit gaps, input bit poke);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({BASE + 32'(4 * i), words[i]});
        end
        garbage();
        pulse_start();
        send_byte(8'(n), gaps);
        send_byte(8'(n >> 8), gaps);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (poke && i == 0 && k == 1) bus.load_start = 1'b1;
                send_byte(8'(words[i] >> (8 * k)), gaps);
                bus.load_start = 1'b0;
            end
        end
        bus.byte_valid = 1'b0;
        // Write cycle of the last word
        check("ready_drop_last", {31'd0, bus.byte_ready}, 32'd0);
        check("done_not_yet",    {31'd0, bus.done},       32'd0);
        tick();
        check("done_set",        {31'd0, bus.done},       32'd1);
        check("core_released",   {31'd0, bus.core_rst_n}, 32'd1);
        check("no_err",          {31'd0, bus.err},        32'd0);
        check("ready_in_done",   {31'd0, bus.byte_ready}, 32'd0);
    endtask

    task automatic bad_len(input logic [15:0] len);
        garbage();
        pulse_start();
        send_byte(len[7:0], 1'b0);
        send_byte(len[15:8], 1'b0);
        bus.byte_valid = 1'b0;
        check("err_set",       {31'd0, bus.err},        32'd1);
        check("err_core_rst",  {31'd0, bus.core_rst_n}, 32'd0);
        check("err_ready",     {31'd0, bus.byte_ready}, 32'd0);
        check("err_done",      {31'd0, bus.done},       32'd0);
        repeat (3) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, bus.byte_ready}, 32'd0);
        check({tag, "_we"},    {31'd0, bus.imem_we},    32'd0);
        check({tag, "_addr"},  bus.imem_addr,           32'd0);
        check({tag, "_wdata"}, bus.imem_wdata,          32'd0);
        check({tag, "_crst"},  {31'd0, bus.core_rst_n}, 32'd0);
        check({tag, "_done"},  {31'd0, bus.done},       32'd0);
        check({tag, "_err"},   {31'd0, bus.err},        32'd0);
    endtask

    initial begin
        bus.load_start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'd0;
        #1;
        check_reset_outputs("rst0");
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Nominal two-word program
        words = '{32'h0010_0513, 32'h0020_0593};
        run_load(2, 1'b0, 1'b0);

        // Zero length, then oversize
        bad_len(16'd0);
        bad_len(16'd257);

        // Maximum length is accepted
        words.delete();
        for (int i = 0; i < IMEM_WORDS; i++) words.push_back($urandom);
        run_load(IMEM_WORDS, 1'b0, 1'b0);

        // Random programs with flow-control gaps; load_start poked mid-data
        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(1, 6);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
            run_load(n, t[0], t == 2);
        end

        // Reset in the middle of the data phase, after the 6th byte
        words = '{$urandom, $urandom};
        exp_q.push_back({BASE, words[0]});
        pulse_start();
        send_byte(8'd2, 1'b0);
        send_byte(8'd0, 1'b0);
        for (int k = 0; k < 4; k++) send_byte(8'(words[0] >> (8 * k)), 1'b0);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'(words[1]);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rstmid");
        bus.byte_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Fresh load restarts at BASE, then reload from DONE
        words = '{$urandom};
        run_load(1, 1'b1, 1'b0);
        words = '{32'h0000_0013};
        run_load(1, 1'b0, 1'b0);

        repeat (5) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter IMEM_WORDS, default 256: instruction-memory capacity in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first loaded word, word-aligned.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 load_start  input  1  one-cycle pulse that begins a program load.
REQ-006 byte_valid  input  1  byte_data holds a valid byte.
REQ-007 byte_data  input  8  program stream byte.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 imem_addr  output  32  instruction-memory write byte address.
REQ-011 imem_wdata  output  32  instruction-memory write data.
REQ-012 core_rst_n  output  1  active-low reset to the core; low while loading.
REQ-013 done  output  1  program loaded; core released.
REQ-014 err  output  1  header length invalid.

Function
REQ-015 A byte transfer SHALL occur only in a cycle with byte_valid=1 and byte_ready=1.
REQ-016 The FSM SHALL have the states IDLE, LEN_LO, LEN_HI, DATA, DONE and ERR.
REQ-017 IDLE: byte_ready=0; load_start SHALL move the FSM to LEN_LO.
REQ-018 LEN_LO/LEN_HI: byte_ready=1; these states SHALL capture a 16-bit word count, little-endian (first byte = bits 7:0).
REQ-019 On LEN_HI transfer, length 0 or length > IMEM_WORDS SHALL go to ERR; otherwise the FSM SHALL go to DATA with word index 0 and byte index 0.
REQ-020 DATA: byte_ready=1; bytes SHALL be assembled little-endian (byte index 0 -> bits 7:0 ... 3 -> bits 31:24).
REQ-021 Transfer of byte index 3 SHALL copy the assembled word into a separate write register.
REQ-022 In the following cycle, imem_we=1 for exactly one cycle, with imem_addr = BASE_ADDR + 4*word_index and imem_wdata = the assembled word.
REQ-023 byte_ready SHALL stay 1 during the write cycle; a byte accepted in that cycle SHALL start the next word without corrupting the word being written.
REQ-024 Word index SHALL increment per write. After the write of word length-1, the FSM SHALL enter DONE on the next edge, and byte_ready SHALL drop from the cycle after the last byte.
REQ-025 DONE: done=1, core_rst_n=1, byte_ready=0; load_start SHALL return the FSM to LEN_LO, with core_rst_n=0 and done=0 on the next cycle.
REQ-026 ERR: err=1, core_rst_n=0, byte_ready=0, no writes; load_start SHALL go to LEN_LO and clear err.
REQ-027 load_start SHALL be ignored in LEN_LO, LEN_HI and DATA.
REQ-028 core_rst_n SHALL be 0 in every state except DONE.
REQ-029 done, err and core_rst_n SHALL be registered outputs.
REQ-030 imem_addr/imem_wdata SHALL hold their last values when imem_we=0.
REQ-031 Bytes presented while byte_ready=0 SHALL be neither consumed nor buffered.

Reset
REQ-032 rst=1 SHALL, asynchronously, force IDLE and clear all counters and registers.
REQ-033 During reset: byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, done=0, err=0.
REQ-034 rst asserted mid-load SHALL abandon the partial word with no further imem_we; the next load SHALL restart at BASE_ADDR.

Verification
REQ-035 Nominal load: load_start, then bytes 02 00 13 05 10 00 93 05 20 00 back-to-back -> imem_we addr 0x0 data 0x00100513, then addr 0x4 data 0x00200593; then done=1, core_rst_n=1.
REQ-036 Zero length: bytes 00 00 -> err=1, core_rst_n=0, imem_we never asserted; a subsequent load_start clears err.
REQ-037 Oversize (IMEM_WORDS=256): bytes 00 01 (length 256) -> accepted; bytes 01 01 (length 257) -> err=1.
REQ-038 Flow control: a 1-word load with random byte_valid gaps, including a byte accepted in the write cycle of a 2-word load -> exact data and addresses, one write per word.
REQ-039 Reset mid-DATA: rst pulsed after the 6th byte -> all outputs at reset values immediately; a fresh load writes first to BASE_ADDR.
REQ-040 Reload: load_start while in DONE -> core_rst_n=0 and done=0 on the next cycle; a new 1-word load of 0x00000013 writes addr 0x0, then DONE.
